// File: rtl/acc_dump.sv
// acc_dump: snapshots the accumulator's wide result on a start request and
// streams it to the uart transmitter as a framed packet:
//   HEADER, NBYTES data bytes (least significant first), 8-bit checksum.
// Each byte goes through a SEND -> WAIT_HI -> WAIT_LO handshake against the
// uart busy flag, so the controller only has to issue one start pulse.
// All outputs are registered.

module acc_dump #(
    parameter int          WIDTH  = 128,
    parameter logic [7:0]  HEADER = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] big,
    input  logic             busy,
    output logic             transmit,
    output logic [7:0]       data_tx,
    output logic             active,
    output logic             done
);

    localparam int NBYTES = WIDTH / 8;
    // A single-byte packet still needs a one-bit index register.
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    // Byte handshake phases.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_WAIT_HI = 2'd2,
        ST_WAIT_LO = 2'd3
    } state_t;

    // Which part of the packet the current byte belongs to.
    typedef enum logic [1:0] {
        PH_HDR  = 2'd0,
        PH_DATA = 2'd1,
        PH_CHK  = 2'd2
    } phase_t;

    // Modulo-256 running sum; the carry out is intentionally dropped.
    function automatic logic [7:0] chk_add(input logic [7:0] sum, input logic [7:0] b);
        logic [8:0] full;
        full = {1'b0, sum} + {1'b0, b};
        return full[7:0];
    endfunction

    // Registered state
    state_t           state_r;
    phase_t           phase_r;
    logic [IDX_W-1:0] idx_r;
    logic [WIDTH-1:0] shadow_r;
    logic [7:0]       chk_r;
    logic             transmit_r;
    logic [7:0]       data_tx_r;
    logic             active_r;
    logic             done_r;

    // Next-state values
    state_t           state_s;
    phase_t           phase_s;
    logic [IDX_W-1:0] idx_s;
    logic [WIDTH-1:0] shadow_s;
    logic [7:0]       chk_s;
    logic             transmit_s;
    logic [7:0]       data_tx_s;
    logic             active_s;
    logic             done_s;

    // Byte that would be issued by the current SEND
    logic [7:0]       cur_byte_s;

    // Select the outgoing byte from the packet phase and byte index.
    always_comb begin
        cur_byte_s = 8'h00;
        case (phase_r)
            PH_HDR:  cur_byte_s = HEADER;
            PH_DATA: cur_byte_s = shadow_r[{idx_r, 3'b000} +: 8];
            PH_CHK:  cur_byte_s = chk_r;
            default: cur_byte_s = 8'h00;
        endcase
    end

    // Next-state and next-output logic for the dump sequencer.
    always_comb begin
        state_s    = state_r;
        phase_s    = phase_r;
        idx_s      = idx_r;
        shadow_s   = shadow_r;
        chk_s      = chk_r;
        data_tx_s  = data_tx_r;
        active_s   = active_r;
        transmit_s = 1'b0;
        done_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // The done cycle is still the tail of the previous packet,
                // so a start arriving alongside done is not accepted.
                if (start && !done_r) begin
                    shadow_s = big;
                    chk_s    = 8'h00;
                    idx_s    = IDX_ZERO;
                    phase_s  = PH_HDR;
                    active_s = 1'b1;
                    state_s  = ST_SEND;
                end else begin
                    state_s  = ST_IDLE;
                end
            end

            ST_SEND: begin
                if (!busy) begin
                    transmit_s = 1'b1;
                    data_tx_s  = cur_byte_s;
                    if (phase_r == PH_DATA) begin
                        chk_s = chk_add(chk_r, cur_byte_s);
                    end else begin
                        chk_s = chk_r;
                    end
                    state_s = ST_WAIT_HI;
                end else begin
                    state_s = ST_SEND;
                end
            end

            ST_WAIT_HI: begin
                if (busy) begin
                    state_s = ST_WAIT_LO;
                end else begin
                    state_s = ST_WAIT_HI;
                end
            end

            ST_WAIT_LO: begin
                if (!busy) begin
                    case (phase_r)
                        PH_HDR: begin
                            phase_s = PH_DATA;
                            idx_s   = IDX_ZERO;
                            state_s = ST_SEND;
                        end
                        PH_DATA: begin
                            if (idx_r == LAST_IDX) begin
                                phase_s = PH_CHK;
                            end else begin
                                idx_s = idx_r + IDX_ONE;
                            end
                            state_s = ST_SEND;
                        end
                        PH_CHK: begin
                            phase_s  = PH_HDR;
                            active_s = 1'b0;
                            done_s   = 1'b1;
                            state_s  = ST_IDLE;
                        end
                        default: begin
                            phase_s  = PH_HDR;
                            active_s = 1'b0;
                            state_s  = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_s = ST_WAIT_LO;
                end
            end

            default: begin
                phase_s  = PH_HDR;
                active_s = 1'b0;
                state_s  = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any packet in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            phase_r    <= PH_HDR;
            idx_r      <= IDX_ZERO;
            shadow_r   <= {WIDTH{1'b0}};
            chk_r      <= 8'h00;
            transmit_r <= 1'b0;
            data_tx_r  <= 8'h00;
            active_r   <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            phase_r    <= phase_s;
            idx_r      <= idx_s;
            shadow_r   <= shadow_s;
            chk_r      <= chk_s;
            transmit_r <= transmit_s;
            data_tx_r  <= data_tx_s;
            active_r   <= active_s;
            done_r     <= done_s;
        end
    end

    assign transmit = transmit_r;
    assign data_tx  = data_tx_r;
    assign active   = active_r;
    assign done     = done_r;

endmodule

// File: tb/tb_acc_dump.sv
// Self-checking bench for acc_dump: table of known packets, hand-written
// corner sequences, and randomized dumps checked against a packet model.

module tb_acc_dump;

    localparam int WIDTH  = 128;
    localparam int NBYTES = WIDTH / 8;
    localparam int PKT    = NBYTES + 2;

    logic             clk   = 1'b0;
    logic             rst   = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] big   = '0;
    logic             busy  = 1'b0;
    logic             transmit;
    logic [7:0]       data_tx;
    logic             active;
    logic             done;

    acc_dump #(.WIDTH(WIDTH), .HEADER(8'hA5)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .big      (big),
        .busy     (busy),
        .transmit (transmit),
        .data_tx  (data_tx),
        .active   (active),
        .done     (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // uart busy model: rises one cycle after a transmit, held bm_hold cycles
    int bm_cnt   = 0;
    int bm_hold  = 10;
    bit bm_force = 1'b0;
    always @(negedge clk) begin
        if (bm_cnt > 0) bm_cnt--;
        if (transmit === 1'b1) bm_cnt = bm_hold + 1;
        busy = bm_force || (bm_cnt >= 1 && bm_cnt <= bm_hold);
    end

    // monitor: collect transmitted bytes and done pulses
    logic [7:0] rx_q[$];
    int done_cnt     = 0;
    int done_rx      = -1;
    int first_tx_cyc = -1;
    int tx_total     = 0;
    bit prev_tx      = 1'b0;
    always @(negedge clk) begin
        if (transmit === 1'b1) begin
            check("tx_not_back_to_back", prev_tx, 1'b0);
            if (rx_q.size() == 0) first_tx_cyc = cyc;
            rx_q.push_back(data_tx);
            tx_total++;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_rx = rx_q.size();
            check("done_after_busy_fall", busy, 1'b0);
        end
        prev_tx = (transmit === 1'b1);
    end

    // reference packet: header, bytes LSB first, sum of data bytes mod 256
    typedef logic [7:0] bq_t[$];
    function automatic bq_t model_packet(input logic [WIDTH-1:0] v);
        bq_t q;
        int sum;
        logic [WIDTH-1:0] t;
        sum = 0;
        q.push_back(8'hA5);
        for (int i = 0; i < NBYTES; i++) begin
            t = v >> (8 * i);
            q.push_back(t[7:0]);
            sum = (sum + int'(t[7:0])) % 256;
        end
        q.push_back(8'(sum));
        return q;
    endfunction

    task automatic check_packet(input string tag, input bq_t exp);
        check({tag, "_len"}, rx_q.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < rx_q.size()) check($sformatf("%s_byte%0d", tag, i), rx_q[i], exp[i]);
        end
    endtask

    task automatic wait_busy_low();
        int n = 0;
        while (busy && n < 200) begin @(negedge clk); n++; end
    endtask

    task automatic clear_mon();
        rx_q.delete();
        done_cnt     = 0;
        done_rx      = -1;
        first_tx_cyc = -1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin @(negedge clk); n++; end
        check({tag, "_done_seen"}, done_cnt, 1);
    endtask

    // full dump with busy low at start: latency, framing, single done
    task automatic run_dump(input logic [WIDTH-1:0] v, input string tag);
        bq_t exp;
        int  c0;
        exp = model_packet(v);
        @(negedge clk);
        wait_busy_low();
        clear_mon();
        big   = v;
        start = 1'b1;
        c0    = cyc;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_active_after_start"}, active, 1'b1);
        wait_done(tag, 3000);
        check({tag, "_hdr_latency"}, first_tx_cyc - c0, 2);
        check({tag, "_bytes_before_done"}, done_rx, PKT);
        repeat (5) @(negedge clk);
        check({tag, "_single_done"}, done_cnt, 1);
        check({tag, "_active_low_after"}, active, 1'b0);
        check({tag, "_data_tx_hold"}, data_tx, exp[PKT-1]);
        check_packet(tag, exp);
    endtask

    typedef struct {
        logic [WIDTH-1:0] v;
        int               hold;
        logic [7:0]       exp_chk;
    } vec_t;

    initial begin
        vec_t vt[6];
        logic [WIDTH-1:0] a_val;
        logic [WIDTH-1:0] b_val;
        int n;
        int sz;

        vt[0] = '{128'h0F0E0D0C0B0A09080706050403020100, 10, 8'h78};
        vt[1] = '{{WIDTH{1'b1}},                         10, 8'hF0};
        vt[2] = '{128'h1,                                3,  8'h01};
        vt[3] = '{128'h01010101010101010101010101010101, 1,  8'h10};
        vt[4] = '{128'h80808080808080808080808080808080, 2,  8'h00};
        vt[5] = '{128'h0,                                4,  8'h00};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_transmit", transmit, 1'b0);
        check("rst_data_tx",  data_tx,  8'h00);
        check("rst_active",   active,   1'b0);
        check("rst_done",     done,     1'b0);
        rst = 1'b0;

        // idle with start low
        repeat (50) @(negedge clk);
        check("idle_no_transmit", tx_total, 0);
        check("idle_active", active, 1'b0);
        check("idle_done",   done,   1'b0);
        check("idle_data_tx", data_tx, 8'h00);

        // table of known packets
        for (int i = 0; i < 6; i++) begin
            bm_hold = vt[i].hold;
            run_dump(vt[i].v, $sformatf("vec%0d", i));
            if (rx_q.size() == PKT) begin
                check($sformatf("vec%0d_header", i), rx_q[0], 8'hA5);
                check($sformatf("vec%0d_chk", i), rx_q[PKT-1], vt[i].exp_chk);
            end else begin
                check($sformatf("vec%0d_size", i), rx_q.size(), PKT);
            end
        end

        // busy held high before and after start: stall in SEND
        bm_hold  = 5;
        a_val    = 128'h00112233445566778899AABBCCDDEEFF;
        bm_force = 1'b1;
        repeat (5) @(negedge clk);
        clear_mon();
        big   = a_val;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (35) @(negedge clk);
        check("busyhold_no_tx", rx_q.size(), 0);
        check("busyhold_active", active, 1'b1);
        bm_force = 1'b0;
        wait_done("busyhold", 3000);
        check_packet("busyhold", model_packet(a_val));

        // big changes and start re-pulsed mid-packet; start on done ignored
        bm_hold = 4;
        a_val   = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        b_val   = 128'h11111111_22222222_33333333_44444444;
        @(negedge clk);
        wait_busy_low();
        clear_mon();
        big   = a_val;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (rx_q.size() < 6 && n < 1000) begin @(negedge clk); n++; end
        big   = b_val;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("midstart_single_done", done_cnt, 1);
        check("midstart_active", active, 1'b0);
        check_packet("midstart", model_packet(a_val));

        // reset in the middle of a packet
        bm_hold = 3;
        a_val   = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        wait_busy_low();
        clear_mon();
        big   = a_val;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (rx_q.size() < 10 && n < 1000) begin @(negedge clk); n++; end
        check("midrst_reached_byte9", rx_q.size(), 10);
        rst = 1'b1;
        #1;
        check("midrst_transmit", transmit, 1'b0);
        check("midrst_active",   active,   1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sz  = rx_q.size();
        repeat (30) @(negedge clk);
        check("midrst_no_more_tx", rx_q.size(), sz);
        check("midrst_no_done", done_cnt, 0);
        run_dump(128'h1, "after_rst");
        if (rx_q.size() == PKT) begin
            check("after_rst_b1",  rx_q[1],     8'h01);
            check("after_rst_chk", rx_q[PKT-1], 8'h01);
        end else begin
            check("after_rst_size", rx_q.size(), PKT);
        end

        // randomized dumps against the model
        for (int k = 0; k < 6; k++) begin
            bm_hold = int'($urandom_range(1, 6));
            run_dump({$urandom, $urandom, $urandom, $urandom}, $sformatf("rand%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
